alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of completed-operation counter.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Ports: req_valid_0/req_valid_1  input  1 each  requester i has an operation pending.
REQ-005 Ports: req_ready_0/req_ready_1  output  1 each  requester i accepted this cycle.
REQ-006 Ports: req_a_i, req_b_i  input  4 each; req_op_i  input  3  operands and opcode of requester i.
REQ-007 Ports: rsp_valid_0/rsp_valid_1  output  1 each; rsp_data_0/rsp_data_1  output  4 each  result to requester i.
REQ-008 Ports: rsp_ready_0/rsp_ready_1  input  1 each  requester i takes the result.
REQ-009 Ports: alu_a, alu_b  output  4; alu_op  output  3  registered operands driven to the shared 4-bit ALU.
REQ-010 Port: alu_res  input  4  ALU 4-bit result (pre-7-segment), combinational from alu_a/alu_b/alu_op.
REQ-011 Ports: busy  output  1  state != IDLE; disp_val  output  4  last captured result, for the 7-segment decoder; done_cnt  output  CNT_W  completed operations.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at a time.
REQ-013 In IDLE, req_ready_i SHALL be high combinationally only for the granted requester i; never both.
REQ-014 Grant: single valid requester SHALL be granted; both valid SHALL grant the one indicated by the round-robin pointer prio.
REQ-015 On req_valid_i & req_ready_i: latch req_a_i/req_b_i/req_op_i into alu_a/alu_b/alu_op, record owner = i, go to EXEC.
REQ-016 EXEC SHALL last exactly one cycle; at its end alu_res SHALL be captured into the result register and disp_val; go to RESP.
REQ-017 In RESP, rsp_valid_owner SHALL be high and rsp_data_owner equal the captured result; the other rsp_valid SHALL be low.
REQ-018 Result and rsp_valid SHALL hold stable while rsp_ready_owner is low; no timeout.
REQ-019 On rsp_ready_owner in RESP: go to IDLE, set prio = ~owner, increment done_cnt (wraps 2^CNT_W-1 -> 0).
REQ-020 Latency: handshake in cycle N -> rsp_valid high in cycle N+2; next acceptance no earlier than cycle after response handshake.
REQ-021 rsp_data for requester not owning SHALL be 0; alu_a/alu_b/alu_op SHALL hold their last value outside EXEC.
REQ-022 Requests arriving during EXEC/RESP SHALL not be accepted and SHALL not be lost (requester holds valid).
REQ-023 Opcodes SHALL be passed through unmodified; 3'b110 (result 0) and 3'b111 (equality, result 4'b0001 or 0) are ordinary operations.

Reset
REQ-024 rst_n low at a rising edge SHALL force: state IDLE, prio 0, owner 0, alu_a/alu_b/alu_op 0, result 0, disp_val 0, done_cnt 0.
REQ-025 Reset mid-operation SHALL abandon it without response and without incrementing done_cnt; req_ready and rsp_valid low while rst_n low.

Structure
REQ-026 Shared package alu_pkg SHALL hold opcode constants (ADD 000, SUB 001, NOT 010, AND 011, OR 100, XOR 101, ZERO 110, EQ 111) and the FSM state enum.
REQ-027 Sub-module rr_arb2 SHALL implement the two-input round-robin grant (inputs: valids, prio; output: grant index, any).
REQ-028 The ALU itself SHALL remain outside this block.

Verification
REQ-029 Req0 A=3,B=5,op=ADD, rsp_ready high -> alu_res 8 captured, rsp_valid_0 at N+2 with rsp_data_0=8, done_cnt=1.
REQ-030 Both valid at reset-exit -> req0 served first; next req1 served; then with both still valid req0 again (alternation).
REQ-031 Req1 A=9,B=9,op=EQ, rsp_ready_1 low 5 cycles -> rsp_valid_1 and data 4'b0001 held 5 cycles, req0 not accepted meanwhile.
REQ-032 Req0 A=0,B=1,op=SUB -> rsp_data_0=4'hF, disp_val=4'hF.
REQ-033 rst_n low during EXEC -> all outputs 0 next cycle, no rsp_valid, done_cnt unchanged at 0.
REQ-034 256 back-to-back completions (CNT_W=8) -> done_cnt wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and request payload for the ALU arbiter.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_ZERO = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the priority pointer.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic       grant_o,
  output logic       any_o
);

  // Grant index selection
  always_comb begin
    any_o   = |valid_i;
    grant_o = 1'b0;
    if (valid_i == 2'b11) begin
      grant_o = prio_i;
    end else if (valid_i[1]) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external 4-bit ALU, one operation in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [OP_W-1:0]   req_op_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,
  input  logic [OP_W-1:0]   req_op_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_data_0,
  output logic [DATA_W-1:0] rsp_data_1,
  input  logic              rsp_ready_0,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              busy,
  output logic [DATA_W-1:0] disp_val,
  output logic [CNT_W-1:0]  done_cnt
);

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic               owner_q, owner_d;
  alu_req_t           alu_q, alu_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;

  logic               grant;
  logic               any_valid;
  logic [1:0]         ready_c;
  logic [1:0]         rsp_valid_c;
  logic [1:0]         rsp_ready_vec;
  alu_req_t           req_sel;

  rr_arb2 u_rr_arb2 (
    .valid_i (2'({req_valid_1, req_valid_0})),
    .prio_i  (prio_q),
    .grant_o (grant),
    .any_o   (any_valid)
  );

  assign rsp_ready_vec = {rsp_ready_1, rsp_ready_0};
  assign req_sel = grant ? alu_req_t'{a: req_a_1, b: req_b_1, op: req_op_1}
                         : alu_req_t'{a: req_a_0, b: req_b_0, op: req_op_0};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      alu_q      <= '0;
      result_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      alu_q      <= alu_d;
      result_q   <= result_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Next-state, operand latch, result capture and acceptance strobes
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    alu_d      = alu_q;
    result_d   = result_q;
    done_cnt_d = done_cnt_q;
    ready_c    = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (rst_n && any_valid) begin
          ready_c[grant] = 1'b1;
          owner_d        = grant;
          alu_d          = req_sel;
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_res;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_vec[owner_q]) begin
          prio_d     = ~owner_q;
          done_cnt_d = done_cnt_q + CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response steering: only the owner sees valid data, and nothing while in reset
  always_comb begin
    rsp_valid_c = 2'b00;
    if (rst_n && (state_q == ST_RESP)) begin
      rsp_valid_c = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign req_ready_0 = ready_c[0];
  assign req_ready_1 = ready_c[1];
  assign rsp_valid_0 = rsp_valid_c[0];
  assign rsp_valid_1 = rsp_valid_c[1];
  assign rsp_data_0  = rsp_valid_c[0] ? result_q : '0;
  assign rsp_data_1  = rsp_valid_c[1] ? result_q : '0;
  assign alu_a       = alu_q.a;
  assign alu_b       = alu_q.b;
  assign alu_op      = alu_q.op;
  assign busy        = (state_q != ST_IDLE);
  assign disp_val    = result_q;
  assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pend;
  logic [3:0] in_a [2];
  logic [3:0] in_b [2];
  logic [2:0] in_op [2];
  logic [1:0] rr;

  logic       req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy;
  logic [3:0] rsp_data_0, rsp_data_1, alu_a, alu_b, alu_res, disp_val;
  logic [2:0] alu_op;
  logic [7:0] done_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state (one transaction record plus bookkeeping)
  bit         m_busy;
  int         m_age;
  bit         m_owner;
  bit         m_prio;
  logic [3:0] m_res, m_disp, m_a, m_b;
  logic [2:0] m_op;
  int         m_done;
  int         served_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(pend[0]), .req_valid_1(pend[1]),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(in_a[0]), .req_b_0(in_b[0]), .req_op_0(in_op[0]),
    .req_a_1(in_a[1]), .req_b_1(in_b[1]), .req_op_1(in_op[1]),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
    .rsp_ready_0(rr[0]), .rsp_ready_1(rr[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .busy(busy), .disp_val(disp_val), .done_cnt(done_cnt)
  );

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return 4'(a + b);
      3'b001:  return 4'(a - b);
      3'b010:  return ~a;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      3'b110:  return 4'h0;
      default: return (a == b) ? 4'h1 : 4'h0;
    endcase
  endfunction

  // external ALU stand-in
  always_comb alu_res = alu_fn(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_owner = 0; m_prio = 0;
    m_res = '0; m_disp = '0; m_a = '0; m_b = '0; m_op = '0; m_done = 0;
  endtask

  task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    pend[i] = 1'b1; in_a[i] = a; in_b[i] = b; in_op[i] = op;
  endtask

  task automatic issue_rand(input int i);
    issue(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
  endtask

  // one clock: compare outputs mid-cycle, advance the model, drop the accepted request after the edge
  task automatic step();
    bit eg_any, eg, ev, acc;
    @(negedge clk);
    eg_any = !m_busy && rst_n && (pend != 2'b00);
    eg     = (pend == 2'b11) ? m_prio : pend[1];
    ev     = rst_n && m_busy && (m_age >= 2);
    check("req_ready_0", req_ready_0, eg_any && !eg);
    check("req_ready_1", req_ready_1, eg_any && eg);
    check("rsp_valid_0", rsp_valid_0, ev && !m_owner);
    check("rsp_valid_1", rsp_valid_1, ev && m_owner);
    if (ev) begin
      check("rsp_data_own", m_owner ? rsp_data_1 : rsp_data_0, m_res);
      check("rsp_data_other", m_owner ? rsp_data_0 : rsp_data_1, 0);
    end
    check("busy", busy, m_busy);
    check("disp_val", disp_val, m_disp);
    check("done_cnt", done_cnt, m_done % 256);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_op", alu_op, m_op);
    acc = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (eg_any) begin
        acc = 1; m_busy = 1; m_age = 1; m_owner = eg;
        m_a = in_a[eg]; m_b = in_b[eg]; m_op = in_op[eg];
        m_res = alu_fn(in_a[eg], in_b[eg], in_op[eg]);
        served_q.push_back(int'(eg));
      end
    end else if (m_age == 1) begin
      m_age = 2; m_disp = m_res;
    end else if (rr[m_owner]) begin
      m_busy = 0; m_prio = !m_owner; m_done++;
    end
    @(posedge clk);
    #1;
    if (acc) pend[eg] = 1'b0;
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while ((m_busy || pend != 2'b00) && n < max);
    check("idle_timeout", m_busy || pend != 2'b00, 0);
  endtask

  initial begin
    int n;
    int target;
    rst_n = 1'b0; pend = 2'b00; rr = 2'b11;
    for (int i = 0; i < 2; i++) begin in_a[i] = '0; in_b[i] = '0; in_op[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    check("rst_disp", disp_val, 0);
    check("rst_done", done_cnt, 0);
    check("rst_busy", busy, 0);

    // both requesters valid at reset exit: alternation 0,1,0
    issue(0, 4'd1, 4'd2, 3'b000);
    issue(1, 4'd7, 4'd3, 3'b001);
    step();
    rst_n = 1'b1;
    served_q.delete();
    n = 0;
    while (served_q.size() < 3 && n < 40) begin
      step();
      if (served_q.size() < 3) begin
        if (!pend[0]) issue_rand(0);
        if (!pend[1]) issue_rand(1);
      end
      n++;
    end
    run_until_idle(20);
    check("rr_first", served_q.size() > 0 ? served_q[0] : -1, 0);
    check("rr_second", served_q.size() > 1 ? served_q[1] : -1, 1);
    check("rr_third", served_q.size() > 2 ? served_q[2] : -1, 0);

    // 3 + 5 = 8 with response two cycles after the handshake
    issue(0, 4'd3, 4'd5, 3'b000);
    step();
    check("add_not_yet", rsp_valid_0, 0);
    step();
    check("add_valid_n2", rsp_valid_0, 1);
    check("add_data", rsp_data_0, 8);
    target = m_done + 1;
    run_until_idle(10);
    check("add_done", done_cnt, target % 256);

    // 0 - 1 wraps to F
    issue(0, 4'd0, 4'd1, 3'b001);
    run_until_idle(10);
    check("sub_disp", disp_val, 4'hF);

    // EQ held 5 cycles with the owner stalled while requester 0 waits
    rr = 2'b00;
    issue(1, 4'd9, 4'd9, 3'b111);
    step();
    issue(0, 4'd1, 4'd1, 3'b000);
    step();
    for (int k = 0; k < 5; k++) begin
      check("eq_hold_valid", rsp_valid_1, 1);
      check("eq_hold_data", rsp_data_1, 4'b0001);
      check("eq_no_accept0", req_ready_0, 0);
      step();
    end
    rr = 2'b11;
    run_until_idle(20);

    // randomised traffic and back-pressure
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) issue_rand(i);
      rr = 2'($urandom_range(0, 3));
      step();
    end
    rr = 2'b11;
    run_until_idle(30);

    // reset while the operation is executing
    issue(0, 4'd7, 4'd2, 3'b000);
    step();
    check("exec_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check("rst_exec_busy", busy, 0);
    check("rst_exec_done", done_cnt, 0);
    check("rst_exec_alu_a", alu_a, 0);
    check("rst_exec_rsp", rsp_valid_0, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_rsp", rsp_valid_0, 0);

    // 256 back-to-back completions wrap the counter
    n = 0;
    while (m_done < 256 && n < 2000) begin
      if (!pend[0]) issue_rand(0);
      if (!pend[1]) issue_rand(1);
      step();
      n++;
    end
    check("wrap_reached", m_done, 256);
    check("wrap_done_cnt", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
